// File: rtl/inst_rom_loader.sv
// Instruction ROM with a byte-stream program loader. The core is held in reset
// until a big-endian word stream (16-bit word-count header first) has been written.
module inst_rom_loader #(
  parameter int INST_MEM_DEPTH = 1024,
  parameter int INST_MEM_AW    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rom_ce_i,
  input  logic [31:0] rom_addr_i,
  output logic [31:0] rom_data_o,
  input  logic        ld_valid_i,
  input  logic [7:0]  ld_data_i,
  output logic        ld_ready_o,
  input  logic        ld_skip_i,
  output logic        core_rst_o,
  output logic        load_done_o,
  output logic [15:0] words_loaded_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_HDR0 = 2'd0,
    S_HDR1 = 2'd1,
    S_DATA = 2'd2,
    S_RUN  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [15:0]            r_word_cnt;
  logic [1:0]             r_byte_cnt;
  logic [23:0]            r_asm;
  logic [INST_MEM_AW-1:0] r_wptr;
  logic [15:0]            r_words_loaded;
  logic                   r_ld_ready;
  logic                   r_core_rst;
  logic                   r_load_done;
  logic [31:0]            r_mem [INST_MEM_DEPTH];

  logic                   w_accept;
  logic                   w_hdr_hi_en;
  logic                   w_hdr_lo_en;
  logic                   w_data_en;
  logic                   w_word_done;
  logic                   w_in_range;
  logic                   w_wr_en;
  logic [INST_MEM_AW-1:0] w_rd_idx;
  logic                   w_unused_addr;

  // Load handshake: a byte transfers on a rising edge where ld_valid_i and
  // ld_ready_o are both high; the host holds ld_data_i stable until then.
  assign w_accept = ld_valid_i && r_ld_ready;

  always_comb begin
    w_next      = r_state;
    w_hdr_hi_en = 1'b0;
    w_hdr_lo_en = 1'b0;
    w_data_en   = 1'b0;
    w_word_done = 1'b0;
    case (r_state)
      S_HDR0: begin
        if (ld_skip_i) begin
          w_next = S_RUN;
        end else if (w_accept) begin
          w_hdr_hi_en = 1'b1;
          w_next      = S_HDR1;
        end
      end
      S_HDR1: begin
        if (w_accept) begin
          w_hdr_lo_en = 1'b1;
          w_next      = ({r_word_cnt[15:8], ld_data_i} == 16'd0) ? S_RUN : S_DATA;
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_data_en = 1'b1;
          if (r_byte_cnt == 2'd3) begin
            w_word_done = 1'b1;
            if (r_words_loaded + 16'd1 == r_word_cnt) begin
              w_next = S_RUN;
            end
          end
        end
      end
      S_RUN:   w_next = S_RUN;
      default: w_next = S_HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_HDR0;
      r_word_cnt     <= 16'd0;
      r_byte_cnt     <= 2'd0;
      r_asm          <= 24'd0;
      r_wptr         <= '0;
      r_words_loaded <= 16'd0;
      r_ld_ready     <= 1'b1;
      r_core_rst     <= 1'b1;
      r_load_done    <= 1'b0;
    end else begin
      r_state     <= w_next;
      // Handshake and core-control outputs follow the state being entered.
      r_ld_ready  <= (w_next != S_RUN);
      r_core_rst  <= (w_next != S_RUN);
      r_load_done <= (w_next == S_RUN);
      if (w_hdr_hi_en) begin
        r_word_cnt[15:8] <= ld_data_i;
      end
      if (w_hdr_lo_en) begin
        r_word_cnt[7:0] <= ld_data_i;
      end
      if (w_data_en) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_asm      <= {r_asm[15:0], ld_data_i};
      end
      if (w_word_done) begin
        r_wptr         <= r_wptr + 1'b1;
        r_words_loaded <= r_words_loaded + 16'd1;
      end
    end
  end

  // Words beyond the array are counted but dropped so they never wrap onto word 0.
  assign w_in_range = (32'(r_words_loaded) < 32'(INST_MEM_DEPTH));
  assign w_wr_en    = w_word_done && w_in_range && !rst;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wptr] <= {r_asm, ld_data_i};
    end
  end

  assign w_rd_idx      = rom_addr_i[INST_MEM_AW+1:2];
  assign w_unused_addr = ^{rom_addr_i[31:INST_MEM_AW+2], rom_addr_i[1:0]};
  assign rom_data_o    = rom_ce_i ? r_mem[w_rd_idx] : 32'h0;

  assign ld_ready_o     = r_ld_ready;
  assign core_rst_o     = r_core_rst;
  assign load_done_o    = r_load_done;
  assign words_loaded_o = r_words_loaded;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_inst_rom_loader.sv
// Directed bench for inst_rom_loader: a full-size instance plus a 4-word instance
// for the overflow case; expectations are queued and checked by a monitor.
module tb_inst_rom_loader;

  localparam logic [1:0] ST_HDR0 = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam int SEL_DATA  = 0;
  localparam int SEL_CRST  = 1;
  localparam int SEL_READY = 2;
  localparam int SEL_DONE  = 3;
  localparam int SEL_WORDS = 4;
  localparam int SEL_STATE = 5;
  localparam int SEL_ACC   = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_s = 1'b1;
  logic        rom_ce = 1'b0;
  logic [31:0] rom_addr = 32'h0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h0;
  logic        ld_skip = 1'b0;
  logic        sel_small = 1'b0;

  logic [31:0] m_rom_data, s_rom_data;
  logic        m_ld_ready, s_ld_ready;
  logic        m_core_rst, s_core_rst;
  logic        m_load_done, s_load_done;
  logic [15:0] m_words, s_words;
  logic [1:0]  m_state, s_state;

  logic [31:0] exp_q[$];
  int          sel_q[$];
  string       name_q[$];
  logic [7:0]  tx_q[$];

  int checks = 0;
  int errors = 0;
  int acc_cnt = 0;
  int acc_base = 0;

  inst_rom_loader u_dut (
    .clk(clk), .rst(rst), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr),
    .rom_data_o(m_rom_data), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_ready_o(m_ld_ready), .ld_skip_i(ld_skip), .core_rst_o(m_core_rst),
    .load_done_o(m_load_done), .words_loaded_o(m_words), .dbg_state_o(m_state)
  );

  inst_rom_loader #(.INST_MEM_DEPTH(4), .INST_MEM_AW(2)) u_small (
    .clk(clk), .rst(rst_s), .rom_ce_i(rom_ce), .rom_addr_i(rom_addr),
    .rom_data_o(s_rom_data), .ld_valid_i(ld_valid), .ld_data_i(ld_data),
    .ld_ready_o(s_ld_ready), .ld_skip_i(ld_skip), .core_rst_o(s_core_rst),
    .load_done_o(s_load_done), .words_loaded_o(s_words), .dbg_state_o(s_state)
  );

  always #5 clk = ~clk;

  logic w_ready;
  logic w_rst;
  assign w_ready = sel_small ? s_ld_ready : m_ld_ready;
  assign w_rst   = sel_small ? rst_s : rst;

  // Independent handshake counter, seen from the host side of the port.
  always @(posedge clk) begin
    if (!w_rst && !ld_skip && ld_valid && w_ready) acc_cnt++;
  end

  // Monitor: drains every queued expectation against the selected DUT.
  always @(negedge clk) begin
    logic [31:0] act;
    logic [31:0] e;
    int          s;
    string       n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      case (s)
        SEL_DATA:  act = sel_small ? s_rom_data : m_rom_data;
        SEL_CRST:  act = {31'd0, sel_small ? s_core_rst : m_core_rst};
        SEL_READY: act = {31'd0, sel_small ? s_ld_ready : m_ld_ready};
        SEL_DONE:  act = {31'd0, sel_small ? s_load_done : m_load_done};
        SEL_WORDS: act = {16'd0, sel_small ? s_words : m_words};
        SEL_STATE: act = {30'd0, sel_small ? s_state : m_state};
        default:   act = 32'(acc_cnt - acc_base);
      endcase
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  task automatic chk(input int s, input logic [31:0] v, input string n);
    sel_q.push_back(s);
    name_q.push_back(n);
    exp_q.push_back(v);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] v, input string n);
    rom_ce   = 1'b1;
    rom_addr = addr;
    chk(SEL_DATA, v, n);
    settle();
  endtask

  task automatic do_reset();
    ld_valid = 1'b0;
    ld_skip  = 1'b0;
    if (sel_small) rst_s = 1'b1; else rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (sel_small) rst_s = 1'b0; else rst = 1'b0;
    acc_base = acc_cnt;
  endtask

  task automatic push_hdr(input logic [15:0] n);
    tx_q.push_back(n[15:8]);
    tx_q.push_back(n[7:0]);
  endtask

  task automatic push_word(input logic [31:0] w);
    tx_q.push_back(w[31:24]);
    tx_q.push_back(w[23:16]);
    tx_q.push_back(w[15:8]);
    tx_q.push_back(w[7:0]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc;
    int   tries;
    tries    = 0;
    ld_valid = 1'b1;
    ld_data  = b;
    forever begin
      acc = w_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      tries++;
      if (tries > 20) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout: got ready=0 expected byte %h accepted", b);
        break;
      end
    end
  endtask

  task automatic send_bytes(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle && i > 0) begin
        ld_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_byte(tx_q.pop_front());
    end
  endtask

  task automatic load_prog_a();
    push_hdr(16'd2);
    push_word(32'h34010005);
    push_word(32'h34020007);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk(SEL_STATE, ST_HDR0, "rst_state");
    chk(SEL_CRST, 1, "rst_core_rst");
    chk(SEL_READY, 1, "rst_ready");
    chk(SEL_DONE, 0, "rst_done");
    chk(SEL_WORDS, 0, "rst_words");
    settle();

    // Held-valid load of two words
    load_prog_a();
    send_bytes(9, 1'b0);
    chk(SEL_CRST, 1, "load9_core_rst");
    chk(SEL_READY, 1, "load9_ready");
    chk(SEL_WORDS, 1, "load9_words");
    settle();
    send_bytes(1, 1'b0);
    chk(SEL_CRST, 0, "load10_core_rst");
    chk(SEL_DONE, 1, "load10_done");
    chk(SEL_READY, 0, "load10_ready");
    chk(SEL_STATE, ST_RUN, "load10_state");
    chk(SEL_WORDS, 2, "load10_words");
    chk(SEL_ACC, 10, "load10_accepted");
    settle();
    ld_data = 8'hee;
    repeat (3) @(posedge clk);
    #1;
    ld_valid = 1'b0;
    chk(SEL_ACC, 10, "run_ignores_bytes");
    chk(SEL_WORDS, 2, "run_words_stable");
    settle();

    fetch(32'h0, 32'h34010005, "fetch_0");
    fetch(32'h4, 32'h34020007, "fetch_4");
    fetch(32'h6, 32'h34020007, "fetch_6");
    fetch(32'h1004, 32'h34020007, "fetch_alias");
    rom_ce = 1'b0;
    chk(SEL_DATA, 32'h0, "fetch_ce0");
    settle();

    // Overwrite with other data, then reload with toggled valid
    do_reset();
    push_hdr(16'd2);
    push_word(32'haabbccdd);
    push_word(32'h11223344);
    send_bytes(10, 1'b0);
    fetch(32'h0, 32'haabbccdd, "prog_b_w0");
    do_reset();
    load_prog_a();
    send_bytes(10, 1'b1);
    ld_valid = 1'b0;
    chk(SEL_ACC, 10, "toggle_accepted");
    chk(SEL_WORDS, 2, "toggle_words");
    chk(SEL_STATE, ST_RUN, "toggle_state");
    settle();
    fetch(32'h0, 32'h34010005, "toggle_w0");
    fetch(32'h4, 32'h34020007, "toggle_w1");

    // Empty header
    do_reset();
    push_hdr(16'd0);
    send_bytes(1, 1'b0);
    chk(SEL_STATE, 1, "zero_hdr1_state");
    settle();
    send_bytes(1, 1'b0);
    ld_valid = 1'b0;
    chk(SEL_STATE, ST_RUN, "zero_state");
    chk(SEL_DONE, 1, "zero_done");
    chk(SEL_WORDS, 0, "zero_words");
    settle();
    fetch(32'h0, 32'h34010005, "zero_mem0");
    fetch(32'h4, 32'h34020007, "zero_mem1");

    // Skip with a byte offered in the same cycle
    do_reset();
    ld_skip  = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 8'h55;
    chk(SEL_STATE, ST_HDR0, "skip_pre_state");
    settle();
    @(posedge clk);
    #1;
    chk(SEL_STATE, ST_RUN, "skip_state");
    chk(SEL_CRST, 0, "skip_core_rst");
    chk(SEL_WORDS, 0, "skip_words");
    settle();
    ld_skip  = 1'b0;
    ld_valid = 1'b0;
    fetch(32'h0, 32'h34010005, "skip_mem0");

    // Reset after six data bytes
    do_reset();
    push_hdr(16'd2);
    push_word(32'h11223344);
    tx_q.push_back(8'h55);
    tx_q.push_back(8'h66);
    send_bytes(8, 1'b0);
    chk(SEL_WORDS, 1, "mid_words_pre");
    settle();
    do_reset();
    chk(SEL_STATE, ST_HDR0, "mid_state");
    chk(SEL_WORDS, 0, "mid_words");
    chk(SEL_CRST, 1, "mid_core_rst");
    settle();
    fetch(32'h0, 32'h11223344, "mid_mem0");
    fetch(32'h4, 32'h34020007, "mid_mem1");
    load_prog_a();
    send_bytes(10, 1'b0);
    ld_valid = 1'b0;
    chk(SEL_STATE, ST_RUN, "reload_state");
    chk(SEL_WORDS, 2, "reload_words");
    settle();
    fetch(32'h0, 32'h34010005, "reload_w0");
    fetch(32'h4, 32'h34020007, "reload_w1");

    // Overflow on the 4-word instance
    sel_small = 1'b1;
    do_reset();
    push_hdr(16'd5);
    push_word(32'h01020304);
    push_word(32'h05060708);
    push_word(32'h090a0b0c);
    push_word(32'h0d0e0f10);
    push_word(32'hdeadbeef);
    send_bytes(22, 1'b0);
    ld_valid = 1'b0;
    chk(SEL_WORDS, 5, "ovf_words");
    chk(SEL_STATE, ST_RUN, "ovf_state");
    chk(SEL_ACC, 22, "ovf_accepted");
    settle();
    fetch(32'h0, 32'h01020304, "ovf_mem0");
    fetch(32'h4, 32'h05060708, "ovf_mem1");
    fetch(32'h8, 32'h090a0b0c, "ovf_mem2");
    fetch(32'hc, 32'h0d0e0f10, "ovf_mem3");
    fetch(32'h10, 32'h01020304, "ovf_alias0");

    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
Name: inst_rom_loader

Overview:
- Instruction memory that feeds the core's fetch port (rom_ce/rom_addr/rom_data) inside the minimal SOPC.
- After reset it accepts a program over a byte-stream load port with a valid/ready handshake, then assembles the bytes into big-endian 32-bit words and writes them sequentially from word 0.
- It holds the core in reset until loading finishes, then serves combinational instruction reads.

Parameters:
- INST_MEM_DEPTH, 1024, number of 32-bit words; must be a power of two.
- INST_MEM_AW, 10, log2(INST_MEM_DEPTH); word-index width.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rom_ce_i  input  1  fetch enable from the core.
- rom_addr_i  input  32  byte address from the core PC.
- rom_data_o  output  32  instruction word.
- ld_valid_i  input  1  load byte valid.
- ld_data_i  input  8  load byte.
- ld_ready_o  output  1  loader can accept a byte.
- ld_skip_i  input  1  skip loading and keep existing memory contents.
- core_rst_o  output  1  reset to the core; high until the program is loaded.
- load_done_o  output  1  high in RUN.
- words_loaded_o  output  16  count of words written since the last reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - state = HDR0.
  - core_rst_o = 1, ld_ready_o = 1, load_done_o = 0, words_loaded_o = 0.
  - Byte counter, word pointer and word-count register are cleared.
  - Memory array is not cleared.
- States are HDR0, HDR1, DATA and RUN. A byte is accepted only when ld_valid_i && ld_ready_o.
- HDR0:
  - If ld_skip_i = 1, go to RUN; ld_skip_i has priority over a byte offered in the same cycle.
  - Otherwise an accepted byte becomes the word count N[15:8] and the state moves to HDR1.
- HDR1: an accepted byte becomes N[7:0]. If the full N = 0, go to RUN; otherwise go to DATA.
- DATA:
  - Bytes are shifted into a 32-bit assembly register, first byte = bits [31:24].
  - On the 4th accepted byte of a word, the cycle's write is mem[wptr] <= {b0, b1, b2, b3}.
  - On that same byte, wptr increments and words_loaded_o increments.
  - If words_loaded_o + 1 == N on that byte, go to RUN on the next edge.
- Overflow: words with index ≥ INST_MEM_DEPTH are consumed and counted but not written. There is no wrap into low memory.
- RUN:
  - ld_ready_o = 0 and incoming bytes are ignored.
  - core_rst_o = 0 and load_done_o = 1.
  - Both outputs are registered; they change on the edge that enters RUN.
  - RUN is left only through rst.
- ld_ready_o is 1 in HDR0, HDR1 and DATA, and is registered from the next state.
- Fetch:
  - rom_data_o = rom_ce_i ? mem[rom_addr_i[INST_MEM_AW+1:2]] : 32'h0, as a combinational read.
  - rom_addr_i[1:0] and the upper address bits are ignored, so addresses alias modulo the depth.
  - Fetch reads are live in every state.
- Reset mid-load: partial words are discarded. Words already written stay in memory. The loader restarts at HDR0, so the host must resend the header.
- ld_skip_i is sampled only in HDR0.
- Reset while in RUN returns to HDR0 with core_rst_o = 1. Raising ld_skip_i after reset restarts the core on the existing program.
- Reads and writes never collide: the core is held in reset during every write.

Test Plan:
- Load N = 2, bytes 00 02 34 01 00 05 34 02 00 07 with ld_valid_i held high. Expected: ld_ready_o high for 10 accepted bytes; mem[0] = 34010005, mem[1] = 34020007; core_rst_o falls on the edge after the 10th byte; words_loaded_o = 2.
- Toggle ld_valid_i every other cycle during the same load. Expected: identical memory contents; no byte lost or duplicated.
- Fetch after the load with rom_ce_i = 1:
  - addr 0x0 gives 34010005.
  - addr 0x4 gives 34020007.
  - addr 0x6 gives 34020007.
  - addr 0x1004 gives 34020007 (alias).
  - rom_ce_i = 0 gives 00000000.
- Header 00 00. Expected: RUN is entered after the 2nd byte and memory is unchanged.
- After a completed load, pulse rst and then hold ld_skip_i = 1 with ld_valid_i = 1. Expected: RUN is reached after one cycle with no byte consumed; mem[0] is still 34010005.
- Assert rst after 6 data bytes. Expected: state HDR0, words_loaded_o = 0, mem[0] keeps the value written before reset; a fresh load then completes normally.
- With INST_MEM_DEPTH = 4, load N = 5. Expected: 5 words counted; mem[0..3] written; word 4 dropped; mem[0] not overwritten.
